// File: rtl/arm_pkg.sv
// Shared encodings for the ARM execute stage: ALU commands, shift types,
// forwarding selects and NZCV bit positions.
package arm_pkg;

  typedef enum logic [3:0] {
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } exe_cmd_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    FWD_REG     = 2'b00,
    FWD_MEM     = 2'b01,
    FWD_WB      = 2'b10,
    FWD_REG_ALT = 2'b11
  } fwd_sel_e;

  localparam int unsigned NZCV_N = 3;
  localparam int unsigned NZCV_Z = 2;
  localparam int unsigned NZCV_C = 1;
  localparam int unsigned NZCV_V = 0;

  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] r);
    logic [63:0] d;
    d = {x, x} >> r;
    return d[31:0];
  endfunction

  function automatic logic [31:0] fwd_mux(input logic [1:0] sel, input logic [31:0] reg_v,
                                          input logic [31:0] mem_v, input logic [31:0] wb_v);
    logic [31:0] v;
    case (fwd_sel_e'(sel))
      FWD_MEM: v = mem_v;
      FWD_WB:  v = wb_v;
      default: v = reg_v;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/exe_stage_if.sv
// EXE/MEM pipeline boundary: the registered outputs of the execute stage.
interface exe_stage_if;
  logic        WB_EN_MEM;
  logic        MEM_R_EN_MEM;
  logic        MEM_W_EN_MEM;
  logic [31:0] alu_res_MEM;
  logic [31:0] st_val_MEM;
  logic [3:0]  dest_MEM;

  modport master (output WB_EN_MEM, MEM_R_EN_MEM, MEM_W_EN_MEM, alu_res_MEM, st_val_MEM, dest_MEM);
  modport slave  (input  WB_EN_MEM, MEM_R_EN_MEM, MEM_W_EN_MEM, alu_res_MEM, st_val_MEM, dest_MEM);
endinterface

// File: rtl/alu.sv
// Execute-stage ALU producing the result and the candidate NZCV flags.
module alu
  import arm_pkg::*;
(
  input  logic [31:0] op1,
  input  logic [31:0] val2,
  input  logic [3:0]  cmd,
  input  logic [3:0]  status_in,
  output logic [31:0] result,
  output logic [3:0]  nzcv
);

  logic [32:0] sum;
  logic        cin;
  logic        arith;
  logic        is_sub;
  logic        logical;

  always_comb begin
    sum     = '0;
    result  = '0;
    nzcv    = status_in;
    arith   = 1'b0;
    is_sub  = 1'b0;
    logical = 1'b0;
    cin     = status_in[NZCV_C];
    case (cmd)
      CMD_MOV: begin result = val2;        logical = 1'b1; end
      CMD_MVN: begin result = ~val2;       logical = 1'b1; end
      CMD_AND: begin result = op1 & val2;  logical = 1'b1; end
      CMD_ORR: begin result = op1 | val2;  logical = 1'b1; end
      CMD_EOR: begin result = op1 ^ val2;  logical = 1'b1; end
      CMD_ADD: begin sum = {1'b0, op1} + {1'b0, val2};                   arith = 1'b1; end
      CMD_ADC: begin sum = {1'b0, op1} + {1'b0, val2} + {32'h0, cin};    arith = 1'b1; end
      // Subtraction as op1 + ~val2 + 1 so bit 32 is directly NOT borrow.
      CMD_SUB: begin sum = {1'b0, op1} + {1'b0, ~val2} + 33'd1;       arith = 1'b1; is_sub = 1'b1; end
      CMD_SBC: begin sum = {1'b0, op1} + {1'b0, ~val2} + {32'h0, cin}; arith = 1'b1; is_sub = 1'b1; end
      default: ;
    endcase

    if (arith) begin
      result       = sum[31:0];
      nzcv[NZCV_C] = sum[32];
      nzcv[NZCV_V] = is_sub ? ((op1[31] != val2[31]) && (result[31] != op1[31]))
                            : ((op1[31] == val2[31]) && (result[31] != op1[31]));
    end
    if (arith || logical) begin
      nzcv[NZCV_N] = result[31];
      nzcv[NZCV_Z] = (result == '0);
    end
  end

endmodule

// File: rtl/val2_gen.sv
// Second-operand generator: memory offset, rotated immediate or shifted register.
module val2_gen
  import arm_pkg::*;
(
  input  logic [31:0] rm_val,
  input  logic [11:0] shifter_operand,
  input  logic        imm,
  input  logic        mem_en,
  output logic [31:0] val2
);

  logic [4:0] amt;

  always_comb begin
    amt  = shifter_operand[11:7];
    val2 = rm_val;
    if (mem_en) begin
      val2 = {20'h0, shifter_operand};
    end else if (imm) begin
      val2 = ror32({24'h0, shifter_operand[7:0]}, {shifter_operand[11:8], 1'b0});
    end else begin
      unique case (shift_e'(shifter_operand[6:5]))
        SH_LSL: val2 = rm_val << amt;
        SH_LSR: val2 = rm_val >> amt;
        SH_ASR: val2 = $unsigned($signed(rm_val) >>> amt);
        SH_ROR: val2 = ror32(rm_val, amt);
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// ARM pipeline execute stage: forwarding, Val2, ALU, branch target,
// NZCV status register and the EXE/MEM register.
module exe_stage
  import arm_pkg::*;
#(
  parameter logic [3:0] STATUS_RST = 4'b0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        WB_EN_EXE,
  input  logic        MEM_R_EN_EXE,
  input  logic        MEM_W_EN_EXE,
  input  logic        S_EXE,
  input  logic        B_EXE,
  input  logic [3:0]  exe_cmd_EXE,
  input  logic [31:0] pc_EXE,
  input  logic [31:0] rn_val_EXE,
  input  logic [31:0] rm_val_EXE,
  input  logic        imm_EXE,
  input  logic [11:0] shifter_operand_EXE,
  input  logic [23:0] signed_imm_24_EXE,
  input  logic [3:0]  dest_EXE,
  input  logic [3:0]  status_EXE,
  input  logic [1:0]  sel_src1,
  input  logic [1:0]  sel_src2,
  input  logic [31:0] fwd_mem_val,
  input  logic [31:0] fwd_wb_val,
  output logic        branch_taken,
  output logic [31:0] branch_addr,
  output logic [3:0]  status_reg,
  exe_stage_if.master mem
);

  logic [31:0] op1;
  logic [31:0] op2r;
  logic [31:0] val2;
  logic [31:0] alu_res;
  logic [3:0]  alu_nzcv;

  assign op1  = fwd_mux(sel_src1, rn_val_EXE, fwd_mem_val, fwd_wb_val);
  assign op2r = fwd_mux(sel_src2, rm_val_EXE, fwd_mem_val, fwd_wb_val);

  val2_gen u_val2_gen (
    .rm_val          (op2r),
    .shifter_operand (shifter_operand_EXE),
    .imm             (imm_EXE),
    .mem_en          (MEM_R_EN_EXE | MEM_W_EN_EXE),
    .val2            (val2)
  );

  alu u_alu (
    .op1       (op1),
    .val2      (val2),
    .cmd       (exe_cmd_EXE),
    .status_in (status_EXE),
    .result    (alu_res),
    .nzcv      (alu_nzcv)
  );

  assign branch_taken = B_EXE;
  assign branch_addr  = pc_EXE + {{6{signed_imm_24_EXE[23]}}, signed_imm_24_EXE, 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_reg <= STATUS_RST;
    end else if (S_EXE && !freeze) begin
      status_reg <= alu_nzcv;
    end
  end

  // Store data is the forwarded Rm, not Val2, since Val2 carries the offset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem.WB_EN_MEM    <= 1'b0;
      mem.MEM_R_EN_MEM <= 1'b0;
      mem.MEM_W_EN_MEM <= 1'b0;
      mem.alu_res_MEM  <= '0;
      mem.st_val_MEM   <= '0;
      mem.dest_MEM     <= '0;
    end else if (!freeze) begin
      mem.WB_EN_MEM    <= WB_EN_EXE;
      mem.MEM_R_EN_MEM <= MEM_R_EN_EXE;
      mem.MEM_W_EN_MEM <= MEM_W_EN_EXE;
      mem.alu_res_MEM  <= alu_res;
      mem.st_val_MEM   <= op2r;
      mem.dest_MEM     <= dest_EXE;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: behavioural model plus directed vectors.
module tb_exe_stage;

  localparam logic [3:0] RST_NZCV = 4'b1010;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        wb_en, mem_r, mem_w, s_f, b_f, imm_f;
  logic [3:0]  cmd, dest, st_exe;
  logic [31:0] pc, rn, rm, fwd_mem, fwd_wb;
  logic [11:0] so;
  logic [23:0] imm24;
  logic [1:0]  sel1, sel2;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [3:0]  status_reg;

  exe_stage_if mem_if ();

  exe_stage #(.STATUS_RST(RST_NZCV)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .freeze              (freeze),
    .WB_EN_EXE           (wb_en),
    .MEM_R_EN_EXE        (mem_r),
    .MEM_W_EN_EXE        (mem_w),
    .S_EXE               (s_f),
    .B_EXE               (b_f),
    .exe_cmd_EXE         (cmd),
    .pc_EXE              (pc),
    .rn_val_EXE          (rn),
    .rm_val_EXE          (rm),
    .imm_EXE             (imm_f),
    .shifter_operand_EXE (so),
    .signed_imm_24_EXE   (imm24),
    .dest_EXE            (dest),
    .status_EXE          (st_exe),
    .sel_src1            (sel1),
    .sel_src2            (sel2),
    .fwd_mem_val         (fwd_mem),
    .fwd_wb_val          (fwd_wb),
    .branch_taken        (branch_taken),
    .branch_addr         (branch_addr),
    .status_reg          (status_reg),
    .mem                 (mem_if.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] r);
    if (sel == 2'd1) return fwd_mem;
    if (sel == 2'd2) return fwd_wb;
    return r;
  endfunction

  // Reference execute semantics computed with wide signed/unsigned arithmetic.
  function automatic void model_exe(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                    input logic [11:0] sh, input logic im, input logic me,
                                    input logic [3:0] st, output logic [31:0] res, output logic [3:0] f);
    logic [31:0] v;
    int unsigned amt;
    longint ua, ub, w, sa, sb, sw;
    logic cy, ov, ar, lg;
    longint ci;
    if (me) v = {20'h0, sh};
    else if (im) begin
      v = {24'h0, sh[7:0]};
      amt = 2 * sh[11:8];
      for (int unsigned i = 0; i < amt; i++) v = {v[0], v[31:1]};
    end else begin
      amt = sh[11:7];
      case (sh[6:5])
        2'd0: v = b << amt;
        2'd1: v = b >> amt;
        2'd2: v = 32'($signed(b) >>> amt);
        default: begin
          v = b;
          for (int unsigned i = 0; i < amt; i++) v = {v[0], v[31:1]};
        end
      endcase
    end
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, v});
    sa = longint'($signed(a));
    sb = longint'($signed(v));
    ci = st[1] ? 64'sd1 : 64'sd0;
    ar = 1'b0; lg = 1'b0; w = 0; sw = 0; cy = st[1]; ov = st[0]; res = '0;
    case (c)
      4'd1: begin res = v;     lg = 1'b1; end
      4'd9: begin res = ~v;    lg = 1'b1; end
      4'd6: begin res = a & v; lg = 1'b1; end
      4'd7: begin res = a | v; lg = 1'b1; end
      4'd8: begin res = a ^ v; lg = 1'b1; end
      4'd2: begin w = ua + ub;      sw = sa + sb;      ar = 1'b1; cy = (w >= 64'sd4294967296); end
      4'd3: begin w = ua + ub + ci; sw = sa + sb + ci; ar = 1'b1; cy = (w >= 64'sd4294967296); end
      4'd4: begin w = ua - ub;            sw = sa - sb;            ar = 1'b1; cy = (w >= 0); end
      4'd5: begin w = ua - ub - (1 - ci); sw = sa - sb - (1 - ci); ar = 1'b1; cy = (w >= 0); end
      default: ;
    endcase
    if (ar) begin
      res = w[31:0];
      ov = (sw > 64'sd2147483647) || (sw < -64'sd2147483648);
    end
    if (ar || lg) f = {res[31], res == 32'h0, cy, ov};
    else f = st;
  endfunction

  logic [3:0]  m_status;
  logic        m_wb, m_mr, m_mw;
  logic [31:0] m_alu, m_st;
  logic [3:0]  m_dest;

  always @(posedge clk or posedge rst) begin
    logic [31:0] r, o2;
    logic [3:0]  f;
    if (rst) begin
      m_status <= RST_NZCV;
      m_wb <= 1'b0; m_mr <= 1'b0; m_mw <= 1'b0;
      m_alu <= '0; m_st <= '0; m_dest <= '0;
    end else if (!freeze) begin
      o2 = pick(sel2, rm);
      model_exe(cmd, pick(sel1, rn), o2, so, imm_f, mem_r | mem_w, st_exe, r, f);
      if (s_f) m_status <= f;
      m_wb <= wb_en; m_mr <= mem_r; m_mw <= mem_w;
      m_alu <= r; m_st <= o2; m_dest <= dest;
    end
  end

  always @(negedge clk) begin
    longint off;
    if (chk_en) begin
      off = longint'({40'h0, imm24});
      if (imm24[23]) off = off - 64'sd16777216;
      check("status_reg", {28'h0, status_reg}, {28'h0, m_status});
      check("WB_EN_MEM", {31'h0, mem_if.WB_EN_MEM}, {31'h0, m_wb});
      check("MEM_R_EN_MEM", {31'h0, mem_if.MEM_R_EN_MEM}, {31'h0, m_mr});
      check("MEM_W_EN_MEM", {31'h0, mem_if.MEM_W_EN_MEM}, {31'h0, m_mw});
      check("alu_res_MEM", mem_if.alu_res_MEM, m_alu);
      check("st_val_MEM", mem_if.st_val_MEM, m_st);
      check("dest_MEM", {28'h0, mem_if.dest_MEM}, {28'h0, m_dest});
      check("branch_taken", {31'h0, branch_taken}, {31'h0, b_f});
      check("branch_addr", branch_addr, 32'(longint'({32'h0, pc}) + off * 4));
    end
  end

  task automatic clear_in();
    freeze = 1'b0; wb_en = 1'b0; mem_r = 1'b0; mem_w = 1'b0; s_f = 1'b0; b_f = 1'b0;
    imm_f = 1'b0; cmd = '0; dest = '0; st_exe = '0; pc = '0; rn = '0; rm = '0;
    fwd_mem = '0; fwd_wb = '0; so = '0; imm24 = '0; sel1 = '0; sel2 = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    tick();
    check("rst status", {28'h0, status_reg}, 32'hA);
    check("rst alu_res", mem_if.alu_res_MEM, 32'h0);
    check("rst dest", {28'h0, mem_if.dest_MEM}, 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    clear_in(); cmd = 4'd2; s_f = 1'b1; imm_f = 1'b1; so = 12'h001; rn = 32'h7FFF_FFFF;
    tick();
    check("add ovf res", mem_if.alu_res_MEM, 32'h8000_0000);
    check("add ovf nzcv", {28'h0, status_reg}, 32'h9);

    clear_in(); cmd = 4'd4; s_f = 1'b1; rn = 32'd5; rm = 32'd5; wb_en = 1'b1; dest = 4'd3;
    tick();
    check("sub zero res", mem_if.alu_res_MEM, 32'h0);
    check("sub zero nzcv", {28'h0, status_reg}, 32'h6);

    clear_in(); freeze = 1'b1; cmd = 4'd2; s_f = 1'b1; imm_f = 1'b1; so = 12'h001;
    rn = 32'h7FFF_FFFF; dest = 4'd9;
    tick();
    check("freeze nzcv", {28'h0, status_reg}, 32'h6);
    check("freeze res", mem_if.alu_res_MEM, 32'h0);
    check("freeze dest", {28'h0, mem_if.dest_MEM}, 32'h3);
    check("freeze wb", {31'h0, mem_if.WB_EN_MEM}, 32'h1);

    clear_in(); cmd = 4'd1; imm_f = 1'b1; so = 12'h2FF; s_f = 1'b1; st_exe = 4'b0011;
    tick();
    check("mov imm rot", mem_if.alu_res_MEM, 32'hF000_000F);
    check("mov nzcv", {28'h0, status_reg}, 32'hB);

    clear_in(); cmd = 4'd1; rm = 32'h8000_0000; so = 12'h240;
    tick();
    check("asr", mem_if.alu_res_MEM, 32'hF800_0000);

    clear_in(); cmd = 4'd4; sel1 = 2'd1; fwd_mem = 32'd10; sel2 = 2'd2; fwd_wb = 32'd3;
    rn = 32'd100; rm = 32'd50;
    tick();
    check("fwd sub", mem_if.alu_res_MEM, 32'd7);

    clear_in(); cmd = 4'd2; mem_w = 1'b1; imm_f = 1'b1; rn = 32'h1000; rm = 32'hDEAD;
    so = 12'h104; sel2 = 2'd2; fwd_wb = 32'd3;
    tick();
    check("str addr", mem_if.alu_res_MEM, 32'h1104);
    check("str data", mem_if.st_val_MEM, 32'd3);

    clear_in(); b_f = 1'b1; pc = 32'h100; imm24 = 24'hFFFFFE;
    #1;
    check("branch taken", {31'h0, branch_taken}, 32'h1);
    check("branch addr", branch_addr, 32'hF8);
    pc = 32'hFFFF_FFFC; imm24 = 24'h000002;
    #1;
    check("branch wrap", branch_addr, 32'h4);
    tick();
    check("bubble res", mem_if.alu_res_MEM, 32'h0);

    clear_in(); cmd = 4'd3; st_exe = 4'b0010; imm_f = 1'b1; so = 12'h001; rn = 32'd1;
    tick();
    check("adc", mem_if.alu_res_MEM, 32'd3);

    for (int i = 0; i < 80; i++) begin
      freeze = ($urandom_range(0, 4) == 0);
      wb_en = 1'($urandom); mem_r = ($urandom_range(0, 5) == 0); mem_w = ($urandom_range(0, 5) == 0);
      s_f = 1'($urandom); b_f = 1'($urandom); imm_f = 1'($urandom);
      cmd = 4'($urandom); dest = 4'($urandom); st_exe = 4'($urandom);
      pc = $urandom; rn = $urandom; rm = $urandom; fwd_mem = $urandom; fwd_wb = $urandom;
      so = 12'($urandom); imm24 = 24'($urandom); sel1 = 2'($urandom); sel2 = 2'($urandom);
      tick();
    end

    clear_in(); cmd = 4'd4; s_f = 1'b1; rn = 32'd1; rm = 32'd2; wb_en = 1'b1; dest = 4'd5;
    tick();
    freeze = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("midrst status", {28'h0, status_reg}, 32'hA);
    check("midrst res", mem_if.alu_res_MEM, 32'h0);
    check("midrst wb", {31'h0, mem_if.WB_EN_MEM}, 32'h0);
    check("midrst dest", {28'h0, mem_if.dest_MEM}, 32'h0);
    tick();
    rst = 1'b0;
    clear_in();
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
